// File: rtl/niossoc_button_pio_db.sv
// Avalon-MM input PIO for buttons/switches: synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, and a maskable registered level interrupt.
module niossoc_button_pio_db #(
  parameter int       WIDTH           = 4,
  parameter int       SYNC_STAGES     = 2,
  parameter int       DEBOUNCE_CYCLES = 50000,
  parameter int       EDGE_MODE       = 1,
  parameter logic     IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] db_dly_q;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= IDLE_VEC;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign db_d = sync_s;
    end else begin : g_debounce
      localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_bit_d;

        // Any sample matching the accepted level restarts the stability window.
        always_comb begin
          cnt_d    = cnt_q + CW'(1);
          db_bit_d = db_q[gi];
          if (sync_s[gi] == db_q[gi]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            db_bit_d = sync_s[gi];
            cnt_d    = '0;
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) cnt_q <= '0;
          else          cnt_q <= cnt_d;
        end

        assign db_d[gi] = db_bit_d;
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_MODE)
      0:       edge_sel = db_q & ~db_dly_q;
      1:       edge_sel = ~db_q & db_dly_q;
      default: edge_sel = (db_q & ~db_dly_q) | (~db_q & db_dly_q);
    endcase
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_d     = mask_q;
    edgecap_d  = edge_sel | edgecap_q;
    readdata_d = '0;
    if (wr_en && address == 2'd1) mask_d = writedata[WIDTH-1:0];
    // A new edge in the same cycle as its clear keeps the bit set.
    if (wr_en && address == 2'd3) edgecap_d = edge_sel | (edgecap_q & ~writedata[WIDTH-1:0]);
    irq_d = |(edgecap_q & mask_q);
    if (chipselect) begin
      case (address)
        2'd0:    readdata_d[WIDTH-1:0] = db_q;
        2'd1:    readdata_d[WIDTH-1:0] = mask_q;
        2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q       <= IDLE_VEC;
      db_dly_q   <= IDLE_VEC;
      mask_q     <= '0;
      edgecap_q  <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      db_q       <= db_d;
      db_dly_q   <= db_q;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign unused_wd = ^writedata;

endmodule

// File: tb/tb_niossoc_button_pio_db.sv
// Randomised and directed checks of niossoc_button_pio_db against a sliding-window
// behavioural model (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, falling edges, idle high).
module tb_niossoc_button_pio_db;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pin delay line, recent synchronised samples, and architectural registers
  logic [3:0]  dq_m [$];
  logic [3:0]  win_m [$];
  logic [3:0]  db_m, db_prev_m, ec_m, mask_m;
  logic        irq_m;
  logic [31:0] rd_m;

  niossoc_button_pio_db #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq_m.delete();
    dq_m.push_back(4'hF);
    dq_m.push_back(4'hF);
    win_m.delete();
    db_m      = 4'hF;
    db_prev_m = 4'hF;
    ec_m      = 4'h0;
    mask_m    = 4'h0;
    irq_m     = 1'b0;
    rd_m      = 32'h0;
  endtask

  task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
  endtask

  // Advance one clock: compute the expected post-edge state from pre-edge inputs, then compare.
  task automatic step();
    logic [3:0]  s_now, db_n, ec_n, mask_n, sel, clr;
    logic        irq_n, wr, all_diff;
    logic [31:0] rd_n;
    if (!reset_n) begin
      @(posedge clk);
      #1;
      model_reset();
      check("rst_rd", readdata, rd_m);
      check("rst_irq", {31'b0, irq}, {31'b0, irq_m});
      return;
    end
    s_now = dq_m[0];
    void'(dq_m.pop_front());
    dq_m.push_back(in_port);
    win_m.push_back(s_now);
    if (win_m.size() > 4) void'(win_m.pop_front());
    // A level is accepted once the last four samples all disagree with it.
    db_n = db_m;
    for (int b = 0; b < 4; b++) begin
      all_diff = (win_m.size() == 4);
      for (int j = 0; j < win_m.size(); j++)
        if (win_m[j][b] == db_m[b]) all_diff = 1'b0;
      if (all_diff) db_n[b] = ~db_m[b];
    end
    sel    = ~db_m & db_prev_m;
    wr     = chipselect && !write_n;
    clr    = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
    ec_n   = sel | (ec_m & ~clr);
    mask_n = (wr && address == 2'd1) ? writedata[3:0] : mask_m;
    irq_n  = |(ec_m & mask_m);
    rd_n   = 32'h0;
    if (chipselect) begin
      if (address == 2'd0)      rd_n = {28'h0, db_m};
      else if (address == 2'd1) rd_n = {28'h0, mask_m};
      else if (address == 2'd3) rd_n = {28'h0, ec_m};
    end
    @(posedge clk);
    #1;
    db_prev_m = db_m;
    db_m      = db_n;
    ec_m      = ec_n;
    mask_m    = mask_n;
    irq_m     = irq_n;
    rd_m      = rd_n;
    check("model_rd", readdata, rd_m);
    check("model_irq", {31'b0, irq}, {31'b0, irq_m});
  endtask

  initial begin
    logic [7:0] bounce;
    bounce = 8'b0000_1000;
    reset_n = 1'b0;
    in_port = 4'hF;
    set_bus(1'b0, 1'b1, 2'd0, 32'h0);
    model_reset();
    #3;
    check("t1_reset_rd", readdata, 32'h0);
    check("t1_reset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // 1: idle reads
    set_bus(1'b1, 1'b1, 2'd0, 32'h0);
    step();
    check("t1_data", readdata, 32'hF);
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t1_edge", readdata, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);

    // 2: press bit 0 and watch the debounce latency through DATA
    set_bus(1'b1, 1'b1, 2'd0, 32'h0);
    in_port = 4'hE;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 6) check("t2_db_still_high", readdata, 32'hF);
      if (n == 7) check("t2_db_fell", readdata, 32'hE);
    end
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t2_edge", readdata, 32'h1);
    check("t2_irq_masked", {31'b0, irq}, 32'h0);

    // 3: mask, then W1C of an unrelated bit and of bit 0
    set_bus(1'b1, 1'b0, 2'd1, 32'h1);
    step();
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t3_irq_set", {31'b0, irq}, 32'h1);
    set_bus(1'b1, 1'b0, 2'd3, 32'h2);
    step();
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t3_w1c_other", readdata, 32'h1);
    check("t3_irq_kept", {31'b0, irq}, 32'h1);
    set_bus(1'b1, 1'b0, 2'd3, 32'h1);
    step();
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t3_w1c", readdata, 32'h0);
    check("t3_irq_clr", {31'b0, irq}, 32'h0);

    // 4: bounce on bit 1
    set_bus(1'b1, 1'b1, 2'd0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      in_port[1] = bounce[k];
      step();
    end
    for (int k = 0; k < 6; k++) step();
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t4_one_capture", readdata, 32'h2);
    set_bus(1'b1, 1'b0, 2'd3, 32'h2);
    step();

    // 5: bit 2 edge lands in the same clock as its W1C
    set_bus(1'b1, 1'b1, 2'd0, 32'h0);
    in_port[2] = 1'b0;
    for (int k = 0; k < 6; k++) step();
    set_bus(1'b1, 1'b0, 2'd3, 32'h4);
    step();
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t5_set_wins", readdata & 32'h4, 32'h4);

    // 6: reset in the middle of a bit-3 count
    in_port = 4'hF;
    for (int k = 0; k < 10; k++) step();
    set_bus(1'b1, 1'b0, 2'd1, 32'hF);
    step();
    in_port = 4'h7;
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    for (int k = 0; k < 3; k++) step();
    check("t6_irq_before", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("t6_async_rd", readdata, 32'h0);
    check("t6_async_irq", {31'b0, irq}, 32'h0);
    model_reset();
    step();
    step();
    reset_n = 1'b1;
    set_bus(1'b1, 1'b1, 2'd0, 32'h0);
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 6) check("t6_db_still_high", readdata, 32'hF);
      if (n == 7) check("t6_db_fell", readdata, 32'h7);
    end
    set_bus(1'b1, 1'b1, 2'd3, 32'h0);
    step();
    check("t6_edge", readdata, 32'h8);

    // Random pins, bus traffic and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (!reset_n) begin
        reset_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        #1;
        check("rand_async_rd", readdata, 32'h0);
        check("rand_async_irq", {31'b0, irq}, 32'h0);
        model_reset();
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) in_port[b] = ~in_port[b];
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
